// File: rtl/fft_stage_sched_pkg.sv
// Shared types, default constants and helpers for the FFT stage scheduler.
package fft_pkg;

  localparam int DEF_LOG2N        = 11;
  localparam int DEF_RD_LAT       = 1;
  localparam int DEF_BF1_LAT      = 1;
  localparam int DEF_CORDIC_DELAY = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } sched_state_e;

  // Reverses the low 'width' bits of x; bits above 'width' come back as zero.
  function automatic logic [31:0] bitRev(input logic [31:0] x, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[width-1-i] = x[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_sched_if.sv
// RAM / butterfly side bus of the FFT stage scheduler.
interface fft_stage_sched_if #(
  parameter int LOG2N = 11
);
  logic             rd_en_o;
  logic [LOG2N-1:0] rd_addr_a_o;
  logic [LOG2N-1:0] rd_addr_b_o;
  logic             ab_vld_o;
  logic [LOG2N-2:0] bf_addr_o;
  logic             c_we_o;
  logic [LOG2N-1:0] c_addr_o;
  logic             d_we_o;
  logic [LOG2N-1:0] d_addr_o;

  modport master (
    output rd_en_o, rd_addr_a_o, rd_addr_b_o, ab_vld_o, bf_addr_o,
           c_we_o, c_addr_o, d_we_o, d_addr_o
  );

  modport slave (
    input rd_en_o, rd_addr_a_o, rd_addr_b_o, ab_vld_o, bf_addr_o,
          c_we_o, c_addr_o, d_we_o, d_addr_o
  );
endinterface

// File: rtl/fft_stage_sched_dly.sv
// Valid+data shift register of fixed depth (>= 1); bubbles travel as bubbles.
module fft_sched_dly #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sched.sv
// Radix-2 DIF FFT stage scheduler: read pairs, twiddle index and delayed write-backs.
// Optional feature: define FFT_SCHED_BITREV_EN to bit-reverse write addresses on the last stage.
module fft_stage_sched
  import fft_pkg::*;
#(
  parameter int LOG2N        = DEF_LOG2N,
  parameter int RD_LAT       = DEF_RD_LAT,
  parameter int BF1_LAT      = DEF_BF1_LAT,
  parameter int CORDIC_DELAY = DEF_CORDIC_DELAY
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [$clog2(LOG2N)-1:0] stage_i,
  input  logic                     hold_i,
  output logic                     busy_o,
  output logic                     done_o,
  fft_stage_sched_if.master        bus
);

  localparam int SW    = $clog2(LOG2N);
  localparam int PW    = LOG2N - 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);

  sched_state_e     state_q;
  logic [SW-1:0]    stage_q, stage_d;
  logic [PW-1:0]    p_q;
  logic             issue, lastPair;
  logic [SW-1:0]    shiftAmt;
  logic [LOG2N-1:0] pExt, hMask, aAddr, bAddr, wrA, wrB;
  logic [PW-1:0]    jIdx;
  logic             dVld, dLast;
  logic [LOG2N-1:0] dAddr;

  assign stage_d  = (stage_i > LAST_STAGE) ? LAST_STAGE : stage_i;
  assign issue    = (state_q == ISSUE) && !hold_i;
  assign lastPair = (p_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      p_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ISSUE;
            stage_q <= stage_d;
            p_q     <= '0;
          end
        end
        ISSUE: begin
          if (!hold_i) begin
            p_q <= p_q + PW'(1);
            if (lastPair) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (dVld && dLast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Group base is p with the j field moved up one bit; b sits H above a.
  always_comb begin
    shiftAmt = LAST_STAGE - stage_q;
    pExt     = {1'b0, p_q};
    hMask    = (LOG2N'(1) << shiftAmt) - LOG2N'(1);
    aAddr    = (((pExt >> shiftAmt) << 1) << shiftAmt) | (pExt & hMask);
    bAddr    = aAddr | (hMask + LOG2N'(1));
    jIdx     = p_q & hMask[PW-1:0];
    wrA      = aAddr;
    wrB      = bAddr;
`ifdef FFT_SCHED_BITREV_EN
    if (stage_q == LAST_STAGE) begin
      wrA = LOG2N'(bitRev(32'(aAddr), LOG2N));
      wrB = LOG2N'(bitRev(32'(bAddr), LOG2N));
    end
`endif
  end

  assign bus.rd_en_o     = issue;
  assign bus.rd_addr_a_o = issue ? aAddr : '0;
  assign bus.rd_addr_b_o = issue ? bAddr : '0;

  fft_sched_dly #(.WIDTH(PW), .DEPTH(RD_LAT)) uBfDly (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (issue),
    .data_i(issue ? jIdx : '0),
    .vld_o (bus.ab_vld_o),
    .data_o(bus.bf_addr_o)
  );

  fft_sched_dly #(.WIDTH(LOG2N), .DEPTH(RD_LAT + BF1_LAT)) uCDly (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (issue),
    .data_i(issue ? wrA : '0),
    .vld_o (bus.c_we_o),
    .data_o(bus.c_addr_o)
  );

  // The d line also carries a last-pair marker so done lines up with the final write.
  fft_sched_dly #(.WIDTH(LOG2N + 1), .DEPTH(RD_LAT + BF1_LAT + CORDIC_DELAY)) uDDly (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (issue),
    .data_i(issue ? {lastPair, wrB} : '0),
    .vld_o (dVld),
    .data_o({dLast, dAddr})
  );

  assign bus.d_we_o   = dVld;
  assign bus.d_addr_o = dAddr;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = dVld && dLast;

endmodule

// File: tb/tb_fft_stage_sched.sv
// Self-checking bench for fft_stage_sched with LOG2N=3 and default latencies.
module tb_fft_stage_sched;

  localparam int LOG2N = 3;
  localparam int NP    = 4;
  localparam int W     = 48;
`ifdef FFT_SCHED_BITREV_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       hold_i = 1'b0;
  logic [1:0] stage_i = 2'd0;
  logic       busy_o, done_o;

  fft_stage_sched_if #(.LOG2N(LOG2N)) bus ();

  fft_stage_sched #(.LOG2N(LOG2N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .stage_i(stage_i),
    .hold_i (hold_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stage;
    int holdLo;
    int holdHi;
    int restartAt;
    int expDone;
  } vec_t;

  int checks = 0;
  int errors = 0;

  bit holdPat[W];
  bit eRd[W], eAb[W], eC[W], eD[W], eBusy[W], eDone[W];
  int eA[W], eB[W], eJ[W], eCa[W], eDa[W];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int rev3(input int x);
    int r = 0;
    for (int i = 0; i < 3; i++) r |= ((x >> i) & 1) << (2 - i);
    return r;
  endfunction

  // Reference: walk the issue index cycle by cycle and place every event at its fixed latency.
  task automatic buildModel(input int stg);
    int s, h, p, a, b, lastD;
    s = (stg > LOG2N - 1) ? LOG2N - 1 : stg;
    h = 1 << (LOG2N - 1 - s);
    p = 0;
    lastD = -1;
    for (int k = 0; k < W; k++) begin
      eRd[k] = 0; eAb[k] = 0; eC[k] = 0; eD[k] = 0; eBusy[k] = 0; eDone[k] = 0;
      eA[k] = 0; eB[k] = 0; eJ[k] = 0; eCa[k] = 0; eDa[k] = 0;
    end
    for (int k = 1; k < W; k++) begin
      if (p < NP && !holdPat[k]) begin
        a = (p / h) * 2 * h + (p % h);
        b = a + h;
        eRd[k] = 1; eA[k] = a; eB[k] = b;
        if (k + 1 < W) begin eAb[k+1] = 1; eJ[k+1] = p % h; end
        if (k + 2 < W) begin eC[k+2] = 1; eCa[k+2] = (BR && s == LOG2N - 1) ? rev3(a) : a; end
        if (k + 17 < W) begin eD[k+17] = 1; eDa[k+17] = (BR && s == LOG2N - 1) ? rev3(b) : b; end
        if (p == NP - 1) lastD = k + 17;
        p++;
      end
    end
    for (int k = 1; k <= lastD && k < W; k++) eBusy[k] = 1;
    if (lastD >= 0 && lastD < W) eDone[lastD] = 1;
  endtask

  task automatic applyStimulus(input int stg, input int restartAt, output int seenDone);
    seenDone = -1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      start_i = (k == 0) || (restartAt > 0 && k == restartAt);
      stage_i = (k == 0) ? 2'(stg) : 2'(stg ^ 1);
      hold_i  = holdPat[k];
      #1;
      checkOutput("rd_en", bus.rd_en_o, eRd[k]);
      if (eRd[k]) begin
        checkOutput("rd_addr_a", bus.rd_addr_a_o, eA[k]);
        checkOutput("rd_addr_b", bus.rd_addr_b_o, eB[k]);
      end
      checkOutput("ab_vld", bus.ab_vld_o, eAb[k]);
      if (eAb[k]) checkOutput("bf_addr", bus.bf_addr_o, eJ[k]);
      checkOutput("c_we", bus.c_we_o, eC[k]);
      if (eC[k]) checkOutput("c_addr", bus.c_addr_o, eCa[k]);
      checkOutput("d_we", bus.d_we_o, eD[k]);
      if (eD[k]) checkOutput("d_addr", bus.d_addr_o, eDa[k]);
      checkOutput("busy", busy_o, eBusy[k]);
      checkOutput("done", done_o, eDone[k]);
      if (done_o === 1'b1 && seenDone < 0) seenDone = k;
    end
    start_i = 1'b0;
    hold_i  = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_en"}, bus.rd_en_o, 0);
    checkOutput({tag, "_rd_a"}, bus.rd_addr_a_o, 0);
    checkOutput({tag, "_rd_b"}, bus.rd_addr_b_o, 0);
    checkOutput({tag, "_ab_vld"}, bus.ab_vld_o, 0);
    checkOutput({tag, "_bf_addr"}, bus.bf_addr_o, 0);
    checkOutput({tag, "_c_we"}, bus.c_we_o, 0);
    checkOutput({tag, "_c_addr"}, bus.c_addr_o, 0);
    checkOutput({tag, "_d_we"}, bus.d_we_o, 0);
    checkOutput({tag, "_d_addr"}, bus.d_addr_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    vec_t vecs[6];
    int seen, stg;
    vecs = '{
      '{0, 0, 0, 0, 21},
      '{2, 0, 0, 0, 21},
      '{1, 0, 0, 0, 21},
      '{0, 2, 3, 0, 23},
      '{0, 0, 0, 5, 21},
      '{3, 0, 0, 0, 21}
    };

    repeat (2) @(negedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      for (int k = 0; k < W; k++) holdPat[k] = (vecs[v].holdLo > 0 && k >= vecs[v].holdLo && k <= vecs[v].holdHi);
      buildModel(vecs[v].stage);
      applyStimulus(vecs[v].stage, vecs[v].restartAt, seen);
      checkOutput($sformatf("done_cycle_v%0d", v), seen, vecs[v].expDone);
    end

    for (int r = 0; r < 4; r++) begin
      stg = $urandom_range(0, 3);
      for (int k = 0; k < W; k++) holdPat[k] = (k >= 1 && k <= 12) ? ($urandom_range(0, 2) == 0) : 1'b0;
      buildModel(stg);
      applyStimulus(stg, 0, seen);
    end

    // Reset during DRAIN: everything clears at once and no done follows.
    for (int k = 0; k < W; k++) holdPat[k] = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      start_i = (k == 0);
      stage_i = 2'd0;
      if (k == 9) begin #1; checkOutput("busy_before_reset", busy_o, 1); end
      if (k == 10) begin
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      #1;
      checkOutput("post_reset_d_we", bus.d_we_o, 0);
      checkOutput("post_reset_done", done_o, 0);
      checkOutput("post_reset_busy", busy_o, 0);
    end

    buildModel(0);
    applyStimulus(0, 0, seen);
    checkOutput("done_cycle_after_reset", seen, 21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stage_sched.md
Name: fft_stage_sched

Overview:
- Sequences one radix-2 DIF FFT stage over an N-point frame held in a dual-port RAM.
- Issues one a/b read pair per cycle and drives the butterfly's twiddle address and ab valid.
- Generates write-back addresses and enables for the butterfly's two result streams. These have different latencies: c is ready after step 1; d is ready after the CORDIC rotation.
- Sits between the frame RAM and one butterfly+CORDIC instance. A top-level FFT FSM calls it once per stage.

Parameters:
- LOG2N, 11, log2 of frame length N (N=2^LOG2N); address width.
- RD_LAT, 1, RAM read latency in cycles (rd_en -> data valid at butterfly inputs).
- BF1_LAT, 1, butterfly step-1 latency (ab_vld -> c valid).
- CORDIC_DELAY, 15, extra d-path latency after c (c valid -> d valid).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start_i  in  1  pulse; begin a stage (accepted only when idle)
- stage_i  in  $clog2(LOG2N)  stage number 0..LOG2N-1, sampled on accepted start
- hold_i  in  1  pause issue of new pairs (in-flight results keep draining)
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse with the last d write
- rd_en_o  out  1  RAM read enable (both ports)
- rd_addr_a_o  out  LOG2N  upper-leg read address
- rd_addr_b_o  out  LOG2N  lower-leg read address
- ab_vld_o  out  1  butterfly input valid
- bf_addr_o  out  LOG2N-1  twiddle index j within group, aligned with ab_vld_o
- c_we_o  out  1  write enable, c result
- c_addr_o  out  LOG2N  c write address
- d_we_o  out  1  write enable, d result
- d_addr_o  out  LOG2N  d write address

Behaviour:
- Reset: every output is 0; FSM in IDLE; counters are 0; all delay-line valid bits are cleared.
- Geometry: H = 2^(LOG2N-1-stage).
  - Issue index p runs 0..N/2-1.
  - Group g = p>>(LOG2N-1-stage); j = p & (H-1).
  - a = g*2H + j; b = a + H.
- FSM states:
  - IDLE -> ISSUE on start_i: latches stage and clears p. rd_en_o first asserts the next cycle.
  - ISSUE: each cycle with hold_i=0, assert rd_en_o with a/b, then p++. With hold_i=1, rd_en_o=0 and p is held.
  - ISSUE -> DRAIN after issuing p=N/2-1.
  - DRAIN: wait until the d-delay line is empty.
  - DRAIN -> IDLE: done_o pulses in the cycle d_we_o carries the last pair; busy_o falls the next cycle.
- Pipeline alignment: shift registers carry {valid, a, b, j}.
  - ab_vld_o / bf_addr_o = rd_en/j delayed RD_LAT.
  - c_we_o / c_addr_o = rd_en/a delayed RD_LAT+BF1_LAT.
  - d_we_o / d_addr_o = rd_en/b delayed RD_LAT+BF1_LAT+CORDIC_DELAY.
- hold_i bubbles propagate as bubbles; the delay lines always shift.
- bf_addr_o restarts at 0 at each group boundary. For H=1 (last stage) it is constant 0. The butterfly angle accumulator relies on j=0 at each group start and +1 per valid.
- start_i while busy is ignored, with no effect on state or outputs.
- An out-of-range stage_i (>=LOG2N) is clamped to LOG2N-1.
- Async reset mid-stage aborts immediately: all outputs go to 0 and no done_o is produced.

Optional Feature:
- Macro: FFT_SCHED_BITREV_EN.
- Defined: when the latched stage = LOG2N-1, c_addr_o and d_addr_o are the LOG2N-bit bit-reversal of a and b. The frame is then written in natural order. Read addresses are unchanged.
- Undefined: write addresses always equal read addresses (in-place).

Decomposition:
- Shared package fft_pkg holds:
  - FSM state typedef (IDLE, ISSUE, DRAIN).
  - Default constants LOG2N, RD_LAT, BF1_LAT, CORDIC_DELAY.
  - A bit-reverse function.
- One sub-module: fft_sched_dly, a parameterised width/depth valid+data shift register with async reset. It is instantiated three times (bf, c, d paths).

Test Plan:
All scenarios use LOG2N=3 and default latencies; start_i is pulsed at cycle T.
- Stage 0, no hold:
  - rd pairs (0,4),(1,5),(2,6),(3,7) at T+1..T+4.
  - bf_addr_o 0,1,2,3 at T+2..T+5.
  - c_addr_o 0,1,2,3 at T+3..T+6.
  - d_addr_o 4,5,6,7 at T+18..T+21.
  - done_o at T+21; busy_o low at T+22.
- Stage 2:
  - rd pairs (0,1),(2,3),(4,5),(6,7).
  - bf_addr_o 0,0,0,0.
  - With FFT_SCHED_BITREV_EN: c_addr_o 0,2,1,3 and d_addr_o 4,6,5,7.
- Stage 1:
  - pairs (0,2),(1,3),(4,6),(5,7).
  - bf_addr_o 0,1,0,1.
- hold_i high at T+2..T+3, stage 0:
  - rd_en_o gaps at T+2,T+3; pair (1,5) issued at T+4.
  - c_we_o and d_we_o show the same two-cycle gap.
  - done_o at T+23.
- start_i re-pulsed at T+5 during stage 0: no effect on sequence or done timing.
- rst_n low at T+10 during DRAIN: all outputs 0 immediately; no done_o.
  - After release, a new start runs a clean stage with no stale d writes.
